// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM access-phase sequencer and the array periphery:
// phase-state encoding, default phase lengths and the address/counter widths.
package sram_pkg;

  localparam int SRAM_AW = 8;
  localparam int SRAM_CW = 4;

  localparam int PRE_CYC_DEF = 2;
  localparam int WL_CYC_DEF  = 3;
  localparam int SA_CYC_DEF  = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    WL    = 3'd2,
    SENSE = 3'd3,
    DONE  = 3'd4
  } phase_state_t;

endpackage

// File: rtl/phase_cnt.sv
// Loadable down-counter with a zero flag; times the length of one access phase.
// It holds at zero rather than wrapping, so a stray decrement cannot restart a phase.
module phase_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sram_phase_seq.sv
// Access-phase sequencer in the clk_copy domain: steps the macro through precharge,
// wordline and (reads only) sense phases of programmable length, then pulses done.
module sram_phase_seq
  import sram_pkg::*;
#(
  parameter int AW      = SRAM_AW,
  parameter int CW      = SRAM_CW,
  parameter int PRE_CYC = PRE_CYC_DEF,
  parameter int WL_CYC  = WL_CYC_DEF,
  parameter int SA_CYC  = SA_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [CW-1:0] cfg_pre,
  input  logic [CW-1:0] cfg_wl,
  input  logic [CW-1:0] cfg_sa,
  output logic          ack,
  output logic          busy,
  output logic          pre_en,
  output logic          wl_en,
  output logic [AW-1:0] wl_addr,
  output logic          we_en,
  output logic          sae_en,
  output logic          done
);

  phase_state_t  state;
  logic          we_lat;
  logic [CW-1:0] wl_len;
  logic [CW-1:0] sa_len;

  logic          cnt_load;
  logic          cnt_dec;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;

  // A zero configuration field selects the built-in default for that phase.
  function automatic logic [CW-1:0] eff_len(input logic [CW-1:0] cfg, input int def);
    return (cfg == '0) ? CW'(def) : cfg;
  endfunction

  assign ack = (state == IDLE) && req && !rst;

  phase_cnt #(
    .CW (CW)
  ) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Counter loads length-1 on entry to each phase, so a phase spans exactly its length.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_load = 1'b1;
          cnt_val  = eff_len(cfg_pre, PRE_CYC) - CW'(1);
        end
      end
      PRE: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = wl_len - CW'(1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WL: begin
        if (cnt_zero) begin
          if (!we_lat) begin
            cnt_load = 1'b1;
            cnt_val  = sa_len - CW'(1);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SENSE: begin
        cnt_dec = !cnt_zero;
      end
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  // Each transition also sets the enables of the state being entered, so every
  // enable is a plain flop that is high for exactly the cycles spent in its phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      pre_en  <= 1'b0;
      wl_en   <= 1'b0;
      we_en   <= 1'b0;
      sae_en  <= 1'b0;
      done    <= 1'b0;
      wl_addr <= '0;
      we_lat  <= 1'b0;
      wl_len  <= '0;
      sa_len  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state   <= PRE;
            busy    <= 1'b1;
            pre_en  <= 1'b1;
            wl_addr <= req_addr;
            we_lat  <= req_we;
            wl_len  <= eff_len(cfg_wl, WL_CYC);
            sa_len  <= eff_len(cfg_sa, SA_CYC);
          end
        end
        PRE: begin
          if (cnt_zero) begin
            state  <= WL;
            pre_en <= 1'b0;
            wl_en  <= 1'b1;
            we_en  <= we_lat;
          end
        end
        WL: begin
          if (cnt_zero) begin
            wl_en <= 1'b0;
            we_en <= 1'b0;
            if (we_lat) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= SENSE;
              sae_en <= 1'b1;
            end
          end
        end
        SENSE: begin
          if (cnt_zero) begin
            state  <= DONE;
            sae_en <= 1'b0;
            done   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          pre_en <= 1'b0;
          wl_en  <= 1'b0;
          we_en  <= 1'b0;
          sae_en <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule
